// File: rtl/arb_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
// Holds the requester count, index width, FSM state enum and an index increment helper.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Modulo-NUM_REQ increment; relies on NUM_REQ being a power of two.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-and-find-first: first set req bit scanning ptr, ptr+1, ... wrapping.
// Zero latency; no state and no backpressure.
module rr_picker
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               anyReq
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ptr + IDX_W'(i);
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/round_robin_arbiter.sv
// 8-way round-robin arbiter: grant registered one cycle after req, held until gntAck, one dead cycle between grants.
// Optional forced release after TIMEOUT unacked grant cycles when ARB_TIMEOUT_EN is defined.
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gntAck,
  output logic               gntValid,
  output logic [IDX_W-1:0]   gntIdx,
  output logic               timeoutPulse
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("round_robin_arbiter: TIMEOUT out of range 2..255");
  end

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_gnt_vld;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_winner;
  logic             w_any_req;

  rr_picker u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .anyReq (w_any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             r_to_pulse;
  logic [CNT_W-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt_vld  <= 1'b0;
      r_gnt_idx  <= '0;
      r_to_pulse <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_to_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_idx <= w_winner;
            r_gnt_vld <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= GRANT;
          end
        end
        GRANT: begin
          // An ack on the expiry edge wins: normal release, no pulse.
          if (gntAck) begin
            r_ptr     <= idx_inc(r_gnt_idx);
            r_gnt_vld <= 1'b0;
            r_to_cnt  <= '0;
            r_state   <= IDLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_ptr      <= idx_inc(r_gnt_idx);
            r_gnt_vld  <= 1'b0;
            r_to_cnt   <= '0;
            r_to_pulse <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign timeoutPulse = r_to_pulse;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_idx <= w_winner;
            r_gnt_vld <= 1'b1;
            r_state   <= GRANT;
          end
        end
        GRANT: begin
          if (gntAck) begin
            r_ptr     <= idx_inc(r_gnt_idx);
            r_gnt_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign timeoutPulse = 1'b0;
`endif

  assign gntValid = r_gnt_vld;
  assign gntIdx   = r_gnt_idx;

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, max GRANT cycles without gntAck before forced release (used only with ARB_TIMEOUT_EN; legal 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request vector, bit i = requester i.
REQ-005 gntAck  input  1  consumer accepts current grant.
REQ-006 gntValid  output  1  grant index valid.
REQ-007 gntIdx  output  3  binary winner index; drives the downstream 3-to-8 decoder select.
REQ-008 timeoutPulse  output  1  one-cycle strobe on forced release.

Function
REQ-009 SHALL implement two states: IDLE, GRANT.
REQ-010 SHALL hold a 3-bit priority pointer ptr; the winner is the first set req bit scanning ptr, ptr+1, ..., wrapping 7->0.
REQ-011 IDLE: on a rising edge with req != 0, SHALL register winner into gntIdx, set gntValid=1, enter GRANT; req==0 stays IDLE, gntValid=0.
REQ-012 Latency: req sampled at edge N -> gntValid=1 immediately after edge N (one cycle).
REQ-013 GRANT: gntIdx and gntValid SHALL remain stable until release, regardless of req changes (including the winner's bit dropping).
REQ-014 Release on gntAck=1 in GRANT: at that edge ptr <= gntIdx+1 mod 8 (7 wraps to 0), gntValid <= 0, state <= IDLE.
REQ-015 Exactly one dead cycle (gntValid=0) SHALL separate consecutive grants.
REQ-016 gntAck in IDLE SHALL be ignored.
REQ-017 gntIdx SHALL hold its last value while gntValid=0.
REQ-018 Single requester repeatedly asserting SHALL be granted every second cycle.
REQ-019 All 8 requesting continuously SHALL be granted in order ptr, ptr+1, ... with no requester granted twice before all others.

Reset
REQ-020 reset=1 SHALL asynchronously force: state=IDLE, ptr=0, gntValid=0, gntIdx=0, timeoutPulse=0, timeout counter=0.
REQ-021 Reset mid-GRANT SHALL drop the grant immediately, with no ack required; first post-reset grant scans from index 0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: SHALL count consecutive GRANT cycles without gntAck; when count reaches TIMEOUT, release as in REQ-014 (ptr advances past gntIdx) and pulse timeoutPulse=1 for one cycle.
REQ-023 gntAck on the same edge the count reaches TIMEOUT SHALL count as a normal release, with timeoutPulse=0.
REQ-024 ARB_TIMEOUT_EN undefined: no counter logic; timeoutPulse tied to 0; grant held indefinitely until gntAck.

Structure
REQ-025 Shared package arb_pkg SHALL hold NUM_REQ=8, IDX_W=3, and the state enum {IDLE, GRANT}.
REQ-026 The combinational rotate-and-find-first logic SHALL be a sub-module rr_picker (inputs req, ptr; outputs winner, anyReq).
REQ-027 The top SHALL contain the state register, ptr, output registers, and the optional timeout counter.

Verification
REQ-028 After reset, req=8'b0000_0100 -> next edge gntValid=1, gntIdx=2; gntAck=1 -> gntValid=0, ptr=3.
REQ-029 req=8'hFF held, gntAck=1 on every GRANT cycle -> gntIdx sequence 0,1,...,7,0, each separated by one gntValid=0 cycle.
REQ-030 Wrap: grant idx 7 acked with req=8'b1000_0001 -> next grant gntIdx=0, then 7.
REQ-031 Reset asserted mid-GRANT (gntIdx=5) -> gntValid=0 with no clock edge; after release, req=8'b0010_0001 grants 0.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT=15, no gntAck -> after 15 GRANT cycles timeoutPulse=1 for one cycle, gntValid=0, next grant skips the timed-out index.
REQ-033 Winner's req bit dropped during GRANT (gntIdx=4) -> gntIdx stays 4 and gntValid stays 1 until gntAck.
